// File: rtl/divider_32bits.sv
// divider_32bits
//   Iterative restoring divider. One shift-subtract step per clock gives a
//   quotient and remainder, signed or unsigned, with ALU-style N/Z/V flags.
//   Signed operands are divided as magnitudes, and the result signs are
//   restored in the FINISH step.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      request, sampled only while busy=0
//   is_signed  1 = two's-complement divide, 0 = unsigned (captured with start)
//   A, B       dividend / divisor (captured with start)
//   busy       operation in flight
//   done       one-cycle pulse; Q/R/flags are valid from this cycle
//   Q, R       quotient / remainder (held until the next FINISH or reset)
//   N, Z, V    Q sign, Q==0, divide-by-zero or signed overflow
module divider_32bits #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             N,
    output logic             Z,
    output logic             V
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder
    logic [WIDTH-1:0] quo_q, quo_d;   // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs_q, dvs_d;   // divisor magnitude
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             div0_q, div0_d;
    logic             ovf_q,  ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             n_q, n_d, z_q, z_d, v_q, v_d;

    // One restoring step. The remainder is always below the divisor, so the
    // shifted value is below 2*divisor. Subtracting at WIDTH+1 bits therefore
    // leaves trial[WIDTH] set exactly when the subtraction borrows.
    logic [WIDTH:0]   sh;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic [WIDTH-1:0] q_fin, r_fin;

    always_comb begin
        sh     = {rem_q, quo_q[WIDTH-1]};
        trial  = sh - {1'b0, dvs_q};
        borrow = trial[WIDTH];
        q_fin  = qneg_q ? -quo_q : quo_q;
        r_fin  = rneg_q ? -rem_q : rem_q;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (B == '0) ? FINISH : CALC;
            CALC:    if (cnt_q == CW'(1)) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        div0_d = div0_q;
        ovf_d  = ovf_q;
        busy_d = busy_q;
        done_d = 1'b0;
        q_d    = q_q;
        r_d    = r_q;
        n_d    = n_q;
        z_d    = z_q;
        v_d    = v_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    div0_d = (B == '0);
                    ovf_d  = is_signed && (A == {1'b1, {(WIDTH-1){1'b0}}})
                                       && (B == '1);
                    qneg_d = is_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
                    rneg_d = is_signed && A[WIDTH-1];
                    // On divide-by-zero the raw dividend is kept for R.
                    if (B == '0)
                        quo_d = A;
                    else
                        quo_d = (is_signed && A[WIDTH-1]) ? -A : A;
                    dvs_d  = (is_signed && B[WIDTH-1]) ? -B : B;
                    rem_d  = '0;
                    cnt_d  = CW'(WIDTH);
                    busy_d = 1'b1;
                end
            end
            CALC: begin
                quo_d = {quo_q[WIDTH-2:0], ~borrow};
                rem_d = borrow ? sh[WIDTH-1:0] : trial[WIDTH-1:0];
                cnt_d = cnt_q - CW'(1);
            end
            FINISH: begin
                busy_d = 1'b0;
                done_d = 1'b1;
                if (div0_q) begin
                    q_d = '1;
                    r_d = quo_q;
                end else begin
                    // most-negative / -1 falls out as 0x80..0 with R=0 here
                    q_d = q_fin;
                    r_d = r_fin;
                end
                n_d = div0_q ? 1'b1 : q_fin[WIDTH-1];
                z_d = div0_q ? 1'b0 : (q_fin == '0);
                v_d = div0_q | ovf_q;
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            div0_q <= 1'b0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            q_q    <= '0;
            r_q    <= '0;
            n_q    <= 1'b0;
            z_q    <= 1'b0;
            v_q    <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
            div0_q <= div0_d;
            ovf_q  <= ovf_d;
            busy_q <= busy_d;
            done_q <= done_d;
            q_q    <= q_d;
            r_q    <= r_d;
            n_q    <= n_d;
            z_q    <= z_d;
            v_q    <= v_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Q    = q_q;
    assign R    = r_q;
    assign N    = n_q;
    assign Z    = z_q;
    assign V    = v_q;

endmodule

// File: doc/divider_32bits.md
Name: divider_32bits

Overview:
- Iterative 32-bit integer divider for the project2 datapath.
- Uses the same add/subtract principle as the ALU adder, but runs it in reverse: one restoring shift-subtract step per clock, recovering a quotient and remainder from a dividend and divisor.
- Sits beside the ALU as a multi-cycle execution unit with a start/busy/done handshake.
- Reports N/Z/V flags with the same meaning the ALU flags carry.

Parameters:
- WIDTH, 32, operand/result width in bits; iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only while busy=0
- is_signed  input  1  1 = two's-complement divide, 0 = unsigned; captured with start
- A  input  WIDTH  dividend; captured with start
- B  input  WIDTH  divisor; captured with start
- busy  output  1  high while an operation is in flight
- done  output  1  single-cycle pulse; Q/R/flags valid from this cycle
- Q  output  WIDTH  quotient
- R  output  WIDTH  remainder
- N  output  1  Q[WIDTH-1]
- Z  output  1  Q == 0
- V  output  1  divide-by-zero, or signed overflow (most-negative / -1)

Behaviour:
- Reset (rst=1 at an edge):
  - state goes to IDLE.
  - busy, done, Q, R, N, Z and V all go to 0.
  - Any in-flight operation is abandoned; no done is produced for it.
- States: IDLE, CALC, FINISH.
- IDLE:
  - start=1 at edge E captures A, B and is_signed.
  - If signed, stores magnitudes plus the quotient sign (A sign XOR B sign) and the remainder sign (A sign).
  - Clears the partial remainder, loads the iteration counter with WIDTH, goes to CALC, and sets busy=1.
- CALC, one iteration per edge:
  - Shift {rem, dividend} left by 1.
  - trial = rem - divisor, computed at WIDTH+1 bits to keep the borrow.
  - If there is no borrow: rem = trial and the new quotient LSB is 1; otherwise the quotient LSB is 0.
  - Counter decrements; after WIDTH iterations, goes to FINISH.
- FINISH (one edge):
  - Applies two's-complement negation to the quotient and/or remainder per the stored signs.
  - Registers Q, R, N, Z and V.
  - Sets done=1 for exactly one cycle, busy=0, and returns to IDLE.
- Latency:
  - Normal operation: done is high in the cycle after edge E+WIDTH+1, i.e. 34 cycles for WIDTH=32.
  - busy is high from after E through the done cycle, exclusive of the done cycle.
- Divide-by-zero (B==0 at capture):
  - Skips CALC; the edge after E goes straight to the FINISH output.
  - Outputs Q = all ones, R = A (raw), V=1, N=1, Z=0.
  - Latency is 2 edges.
- Signed overflow (is_signed, A=0x80000000, B=0xFFFFFFFF):
  - Takes the full latency.
  - Outputs Q=0x80000000, R=0, V=1, N=1, Z=0.
- Signed rounding:
  - Quotient truncates toward zero.
  - The remainder takes the sign of the dividend, so A = Q*B + R always holds otherwise.
- start while busy=1 is ignored; the new request is not queued.
- start in the same cycle done is high is accepted (busy=0 in that cycle), allowing back-to-back operations.
- Q/R/flags hold their last values between done pulses; they change only at a FINISH edge or at reset.
- V=0 and N/Z follow Q for all other operations.

Test Plan:
- Unsigned, A=100, B=7 -> after 34 cycles done=1 for one cycle, Q=14, R=2, N=0, Z=0, V=0; busy=1 for the 33 preceding cycles.
- Signed, A=-7 (0xFFFFFFF9), B=2 -> Q=0xFFFFFFFD (-3), R=0xFFFFFFFF (-1), N=1, Z=0, V=0.
- Corner quotients:
  - Unsigned A=3, B=10 -> Q=0, R=3, Z=1.
  - Unsigned A=0xFFFFFFFF, B=1 -> Q=0xFFFFFFFF, R=0, N=1.
- Divide-by-zero, A=0x1234, B=0 -> done on the 2nd cycle after start, Q=0xFFFFFFFF, R=0x1234, V=1.
- Signed overflow, A=0x80000000, B=0xFFFFFFFF -> Q=0x80000000, R=0, V=1, N=1.
- Handshake and reset:
  - start pulsed again mid-operation -> ignored; exactly one done with the first operation's result.
  - rst asserted at cycle 10 of an operation -> all outputs 0 next cycle and no done.
  - A new start then completes normally with correct results.
